axi_chan_fifo_bank: RTL and testbench

- Single-clock bank of NUM_CHAN independent valid/ready channel buffers on a master port, between the external master and the crossbar.
- Used for timing isolation and rate absorption where no clock crossing is required.
- Each channel is parametrically either a combinational pass-through or a first-word-fall-through FIFO of DEPTH entries.
- Payloads are packed per channel into DATA_WIDTH-bit slots. The integrator pads narrower AXI channels (AW/W/AR/R/B).

---
 rtl/axi_chan_fifo_bank.sv | 96 +++++++++
 tb/tb_axi_chan_fifo_bank.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_chan_fifo_bank.sv
// Bank of independent valid/ready channel buffers: each channel is either a
// combinational pass-through or a first-word-fall-through FIFO.
module axi_chan_fifo_bank #(
  parameter int                  NUM_CHAN     = 5,
  parameter int                  DATA_WIDTH   = 64,
  parameter int                  DEPTH        = 4,
  parameter logic [NUM_CHAN-1:0] CHAN_MODE    = {NUM_CHAN{1'b1}},
  parameter int                  AFULL_THRESH = DEPTH - 1
) (
  input  logic                                     XBAR_CLK,
  input  logic                                     sysReset,
  input  logic [NUM_CHAN-1:0]                      in_valid,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0]           in_data,
  output logic [NUM_CHAN-1:0]                      in_ready,
  output logic [NUM_CHAN-1:0]                      out_valid,
  output logic [NUM_CHAN*DATA_WIDTH-1:0]           out_data,
  input  logic [NUM_CHAN-1:0]                      out_ready,
  input  logic [NUM_CHAN-1:0]                      chan_flush,
  output logic [NUM_CHAN*$clog2(DEPTH+1)-1:0]      chan_level,
  output logic [NUM_CHAN-1:0]                      chan_afull
);

  localparam int              LW      = $clog2(DEPTH + 1);
  localparam int              PW      = $clog2(DEPTH);
  localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0]   AFULL_L = LW'(AFULL_THRESH);

  for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
    if (CHAN_MODE[gi]) begin : g_fifo
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
      logic [LW-1:0]         count_q, count_d;
      logic                  afull_q, afull_d;
      logic                  init_q;
      logic                  rdy, push, pop;

      // init_q holds in_ready low until the first edge after reset release
      always_comb begin
        rdy      = init_q & (count_q != DEPTH_L) & ~chan_flush[gi];
        push     = in_valid[gi] & rdy;
        pop      = (count_q != '0) & out_ready[gi];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (chan_flush[gi]) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (push) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
          case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
        end
        afull_d = (count_d >= AFULL_L);
      end

      always_ff @(posedge XBAR_CLK or negedge sysReset) begin
        if (!sysReset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
          afull_q  <= 1'b0;
          init_q   <= 1'b0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
          afull_q  <= afull_d;
          init_q   <= 1'b1;
        end
      end

      always_ff @(posedge XBAR_CLK) begin
        if (push) mem[wr_ptr_q] <= in_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end

      assign in_ready[gi]                           = rdy;
      assign out_valid[gi]                          = (count_q != '0);
      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH]  = mem[rd_ptr_q];
      assign chan_level[gi*LW +: LW]                = count_q;
      assign chan_afull[gi]                         = afull_q;
    end else begin : g_bypass
      assign in_ready[gi]                           = out_ready[gi];
      assign out_valid[gi]                          = in_valid[gi];
      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH]  = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign chan_level[gi*LW +: LW]                = '0;
      assign chan_afull[gi]                         = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_chan_fifo_bank.sv
// Scoreboard bench for axi_chan_fifo_bank: an all-FIFO instance plus one with
// channel 4 in bypass.
module tb_axi_chan_fifo_bank;
  localparam int NC = 5;
  localparam int DW = 64;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]    a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_afull;
  logic [NC*DW-1:0] a_in_data, a_out_data;
  logic [NC*LW-1:0] a_level;
  logic [NC-1:0]    b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_afull;
  logic [NC*DW-1:0] b_in_data, b_out_data;
  logic [NC*LW-1:0] b_level;

  axi_chan_fifo_bank #(.NUM_CHAN(NC), .DATA_WIDTH(DW), .DEPTH(4)) u_dut_a (
    .XBAR_CLK(clk), .sysReset(rst_n),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .chan_flush(a_flush), .chan_level(a_level), .chan_afull(a_afull)
  );

  axi_chan_fifo_bank #(.NUM_CHAN(NC), .DATA_WIDTH(DW), .DEPTH(4), .CHAN_MODE(5'b01111)) u_dut_b (
    .XBAR_CLK(clk), .sysReset(rst_n),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .chan_flush(b_flush), .chan_level(b_level), .chan_afull(b_afull)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [63:0] sb2_q[$];
  logic [63:0] exp_d;

  function automatic logic [63:0] a_out(int ch);
    return a_out_data[ch*DW +: DW];
  endfunction

  function automatic logic [2:0] a_lvl(int ch);
    return a_level[ch*LW +: LW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_in_valid = '0; a_in_data = '0; a_out_ready = '0; a_flush = '0;
    b_in_valid = '0; b_in_data = '0; b_out_ready = '0; b_flush = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    n_vec++; if (a_in_ready !== 5'b00000) begin n_err++; $display("FAIL rst_in_ready: got %b want 00000", a_in_ready); end
    n_vec++; if (a_out_valid !== 5'b00000) begin n_err++; $display("FAIL rst_out_valid: got %b want 00000", a_out_valid); end
    n_vec++; if (a_level !== 15'd0) begin n_err++; $display("FAIL rst_level: got %h want 0", a_level); end
    n_vec++; if (b_in_ready !== 5'b00000) begin n_err++; $display("FAIL rst_b_in_ready: got %b want 00000", b_in_ready); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (a_in_ready !== 5'b00000) begin n_err++; $display("FAIL rel_before_edge: got %b want 00000", a_in_ready); end
    tick();
    n_vec++; if (a_in_ready !== 5'b11111) begin n_err++; $display("FAIL rel_in_ready: got %b want 11111", a_in_ready); end
    n_vec++; if (b_in_ready !== 5'b01111) begin n_err++; $display("FAIL rel_b_in_ready: got %b want 01111", b_in_ready); end
    n_vec++; if (a_afull !== 5'b00000) begin n_err++; $display("FAIL rel_afull: got %b want 00000", a_afull); end
  endtask

  task automatic test_fill_drain();
    logic [63:0] vals [4];
    vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33; vals[3] = 64'h44;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      a_in_valid[0] = 1'b1;
      a_in_data[0 +: DW] = vals[i];
      #1;
      n_vec++; if (a_in_ready[0] !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d]: got %b want 1", i, a_in_ready[0]); end
      sb_q.push_back(vals[i]);
      tick();
      n_vec++; if (a_lvl(0) !== 3'(i + 1)) begin n_err++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, a_lvl(0), i + 1); end
      n_vec++; if (a_afull[0] !== (i + 1 >= 3)) begin n_err++; $display("FAIL fill_afull[%0d]: got %b want %b", i, a_afull[0], (i + 1 >= 3)); end
    end
    a_in_data[0 +: DW] = 64'h55;
    #1;
    n_vec++; if (a_in_ready[0] !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", a_in_ready[0]); end
    n_vec++; if (a_out(0) !== sb_q[0]) begin n_err++; $display("FAIL full_head: got %h want %h", a_out(0), sb_q[0]); end
    tick();
    n_vec++; if (a_lvl(0) !== 3'd4) begin n_err++; $display("FAIL full_hold_level: got %0d want 4", a_lvl(0)); end
    a_in_valid[0] = 1'b0;
    a_out_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_d = sb_q.pop_front();
      n_vec++; if (a_out_valid[0] !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b want 1", k, a_out_valid[0]); end
      n_vec++; if (a_out(0) !== exp_d) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", k, a_out(0), exp_d); end
      $display("pop ch0 data=%h", a_out(0));
      tick();
      n_vec++; if (a_lvl(0) !== 3'(3 - k)) begin n_err++; $display("FAIL drain_level[%0d]: got %0d want %0d", k, a_lvl(0), 3 - k); end
    end
    n_vec++; if (a_out_valid[0] !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", a_out_valid[0]); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    a_in_valid[1] = 1'b1;
    a_out_ready[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a_in_data[1*DW +: DW] = 64'h100 + 64'(k);
      #1;
      n_vec++; if (a_in_ready[1] !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, a_in_ready[1]); end
      if (k > 0) begin
        exp_d = sb_q.pop_front();
        n_vec++; if (a_lvl(1) !== 3'd1) begin n_err++; $display("FAIL b2b_level[%0d]: got %0d want 1", k, a_lvl(1)); end
        n_vec++; if (a_out_valid[1] !== 1'b1 || a_out(1) !== exp_d) begin
          n_err++; $display("FAIL b2b_data[%0d]: got v=%b %h want v=1 %h", k, a_out_valid[1], a_out(1), exp_d);
        end
        $display("pop ch1 data=%h", a_out(1));
      end
      sb_q.push_back(64'h100 + 64'(k));
      tick();
    end
    a_in_valid[1] = 1'b0;
    #1;
    exp_d = sb_q.pop_front();
    n_vec++; if (a_out(1) !== exp_d) begin n_err++; $display("FAIL b2b_last: got %h want %h", a_out(1), exp_d); end
    tick();
    n_vec++; if (a_lvl(1) !== 3'd0) begin n_err++; $display("FAIL b2b_end_level: got %0d want 0", a_lvl(1)); end
    idle_inputs();
  endtask

  task automatic test_full_pop();
    idle_inputs();
    a_in_valid[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_in_data[2*DW +: DW] = 64'h200 + 64'(k);
      sb_q.push_back(64'h200 + 64'(k));
      tick();
    end
    a_in_data[2*DW +: DW] = 64'h2FF;
    a_out_ready[2] = 1'b1;
    #1;
    n_vec++; if (a_in_ready[2] !== 1'b0) begin n_err++; $display("FAIL fullpop_ready: got %b want 0", a_in_ready[2]); end
    exp_d = sb_q.pop_front();
    n_vec++; if (a_out(2) !== exp_d) begin n_err++; $display("FAIL fullpop_data: got %h want %h", a_out(2), exp_d); end
    tick();
    a_in_valid[2] = 1'b0;
    a_out_ready[2] = 1'b0;
    #1;
    n_vec++; if (a_lvl(2) !== 3'd3) begin n_err++; $display("FAIL fullpop_level: got %0d want 3", a_lvl(2)); end
    n_vec++; if (a_in_ready[2] !== 1'b1) begin n_err++; $display("FAIL fullpop_ready_next: got %b want 1", a_in_ready[2]); end
    a_out_ready[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_d = sb_q.pop_front();
      n_vec++; if (a_out(2) !== exp_d) begin n_err++; $display("FAIL fullpop_drain[%0d]: got %h want %h", k, a_out(2), exp_d); end
      $display("pop ch2 data=%h", a_out(2));
      tick();
    end
    n_vec++; if (a_out_valid[2] !== 1'b0) begin n_err++; $display("FAIL fullpop_empty: got %b want 0", a_out_valid[2]); end
    idle_inputs();
  endtask

  task automatic test_flush();
    idle_inputs();
    a_in_valid[4] = 1'b1;
    a_out_ready[4] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      a_in_data[4*DW +: DW] = 64'h400 + 64'(c);
      a_in_valid[3] = (c <= 3);
      a_in_data[3*DW +: DW] = (c == 3) ? 64'h3AA : 64'h301 + 64'(c);
      a_flush[3] = (c == 2);
      a_out_ready[3] = (c == 4);
      #1;
      if (c == 2) begin
        n_vec++; if (a_in_ready[3] !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", a_in_ready[3]); end
        n_vec++; if (a_lvl(3) !== 3'd2) begin n_err++; $display("FAIL preflush_level: got %0d want 2", a_lvl(3)); end
      end
      if (c == 3) begin
        n_vec++; if (a_lvl(3) !== 3'd0 || a_out_valid[3] !== 1'b0) begin
          n_err++; $display("FAIL postflush: got lvl=%0d v=%b want lvl=0 v=0", a_lvl(3), a_out_valid[3]);
        end
        n_vec++; if (a_in_ready[3] !== 1'b1) begin n_err++; $display("FAIL postflush_ready: got %b want 1", a_in_ready[3]); end
      end
      if (c == 4) begin
        n_vec++; if (a_out_valid[3] !== 1'b1 || a_out(3) !== 64'h3AA) begin
          n_err++; $display("FAIL flush_reuse: got v=%b %h want v=1 %h", a_out_valid[3], a_out(3), 64'h3AA);
        end
      end
      if (c == 5) begin
        n_vec++; if (a_lvl(3) !== 3'd0) begin n_err++; $display("FAIL flush_reuse_level: got %0d want 0", a_lvl(3)); end
      end
      if (c > 0) begin
        exp_d = sb2_q.pop_front();
        n_vec++; if (a_out_valid[4] !== 1'b1 || a_out(4) !== exp_d) begin
          n_err++; $display("FAIL flush_ch4[%0d]: got v=%b %h want v=1 %h", c, a_out_valid[4], a_out(4), exp_d);
        end
        $display("pop ch4 data=%h", a_out(4));
      end
      sb2_q.push_back(64'h400 + 64'(c));
      tick();
    end
    a_in_valid[4] = 1'b0;
    #1;
    exp_d = sb2_q.pop_front();
    n_vec++; if (a_out(4) !== exp_d) begin n_err++; $display("FAIL flush_ch4_last: got %h want %h", a_out(4), exp_d); end
    tick();
    idle_inputs();
  endtask

  task automatic test_bypass();
    idle_inputs();
    b_in_valid[4] = 1'b1;
    b_in_data[4*DW +: DW] = 64'hDEAD;
    #1;
    n_vec++; if (b_out_valid[4] !== 1'b1 || b_out_data[4*DW +: DW] !== 64'hDEAD) begin
      n_err++; $display("FAIL byp_pass: got v=%b %h want v=1 dead", b_out_valid[4], b_out_data[4*DW +: DW]);
    end
    n_vec++; if (b_in_ready[4] !== 1'b0) begin n_err++; $display("FAIL byp_ready_lo: got %b want 0", b_in_ready[4]); end
    n_vec++; if (b_level[4*LW +: LW] !== 3'd0 || b_afull[4] !== 1'b0) begin
      n_err++; $display("FAIL byp_level: got %0d/%b want 0/0", b_level[4*LW +: LW], b_afull[4]);
    end
    b_out_ready[4] = 1'b1;
    b_flush[4] = 1'b1;
    b_in_data[4*DW +: DW] = 64'hBEEF;
    #1;
    n_vec++; if (b_in_ready[4] !== 1'b1) begin n_err++; $display("FAIL byp_ready_hi: got %b want 1", b_in_ready[4]); end
    n_vec++; if (b_out_data[4*DW +: DW] !== 64'hBEEF) begin n_err++; $display("FAIL byp_data2: got %h want beef", b_out_data[4*DW +: DW]); end
    b_in_valid[4] = 1'b0;
    #1;
    n_vec++; if (b_out_valid[4] !== 1'b0) begin n_err++; $display("FAIL byp_valid_lo: got %b want 0", b_out_valid[4]); end
    tick();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    a_in_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_in_data[0 +: DW] = 64'h501 + 64'(k);
      tick();
    end
    a_in_valid[0] = 1'b0;
    #1;
    n_vec++; if (a_lvl(0) !== 3'd3 || a_out_valid[0] !== 1'b1) begin
      n_err++; $display("FAIL arst_pre: got lvl=%0d v=%b want lvl=3 v=1", a_lvl(0), a_out_valid[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (a_out_valid !== 5'b00000 || a_lvl(0) !== 3'd0) begin
      n_err++; $display("FAIL arst_now: got v=%b lvl=%0d want v=00000 lvl=0", a_out_valid, a_lvl(0));
    end
    n_vec++; if (a_in_ready !== 5'b00000 || a_afull !== 5'b00000) begin
      n_err++; $display("FAIL arst_ready: got r=%b af=%b want 00000/00000", a_in_ready, a_afull);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++; if (a_in_ready !== 5'b11111) begin n_err++; $display("FAIL arst_release: got %b want 11111", a_in_ready); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_pop();
    test_flush();
    test_bypass();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
